// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, NOP word,
// default reset PC and a word-alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_ENCODING     = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: redirect load (word-aligned) has priority over +4 advance.
// Arithmetic wraps modulo 2^32.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= word_align(load_pc);
    end else if (inc) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request FSM, one-word stall buffer, IF/ID outputs.
// Optional macro FETCH_PERF_EN adds the fetch_count delivery counter.
//
// Handshake: imem_req/imem_addr are driven from registered state only; once
// imem_req is high they stay stable until a cycle with imem_ack=1, and
// imem_ack is ignored whenever imem_req is low.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
`endif
  output logic [1:0]  state_dbg
);

  fetch_state_t state, next_state;

  logic        started;
  logic [31:0] pc, pc_plus4;
  logic [31:0] drain_addr;
  logic [31:0] buf_instr, buf_pc;

  logic req_live, ack_ok;
  logic pc_inc, pc_load;
  logic deliver_now, deliver_buf, bubble;
  logic buf_load, drain_load;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_pc  (redirect_pc),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // No request is live in the first cycle after reset, so a late ack from an
  // abandoned transaction cannot be mistaken for data.
  assign req_live  = started && (state != S_HOLD);
  assign ack_ok    = imem_ack && req_live;
  assign imem_req  = req_live;
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    deliver_now = 1'b0;
    deliver_buf = 1'b0;
    bubble      = 1'b0;
    buf_load    = 1'b0;
    drain_load  = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_load = 1'b1;
          bubble  = 1'b1;
          if (req_live && !imem_ack) begin
            // Outstanding request must complete on its old address.
            next_state = S_DRAIN;
            drain_load = 1'b1;
          end
        end else if (ack_ok) begin
          if (stall) begin
            buf_load   = 1'b1;
            next_state = S_HOLD;
          end else begin
            deliver_now = 1'b1;
            pc_inc      = 1'b1;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_load    = 1'b1;
          bubble     = 1'b1;
          next_state = S_REQ;
        end else if (!stall) begin
          deliver_buf = 1'b1;
          pc_inc      = 1'b1;
          next_state  = S_REQ;
        end
      end
      S_DRAIN: begin
        pc_load = redirect;
        bubble  = redirect || !stall;
        if (imem_ack) begin
          next_state = S_REQ;
        end
      end
      default: begin
        next_state = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started    <= 1'b0;
      drain_addr <= 32'd0;
      buf_instr  <= NOP_INSTR;
      buf_pc     <= 32'd0;
    end else begin
      started <= 1'b1;
      if (drain_load) begin
        drain_addr <= pc;
      end
      if (buf_load) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pc_plus4;
      end
    end
  end

  // PC_out is left untouched by bubbles; only valid_out qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_out          <= 32'd0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else if (deliver_now) begin
      PC_out          <= pc_plus4;
      instruction_out <= imem_rdata;
      valid_out       <= 1'b1;
    end else if (deliver_buf) begin
      PC_out          <= buf_pc;
      instruction_out <= buf_instr;
      valid_out       <= 1'b1;
    end else if (bubble) begin
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (deliver_now || deliver_buf) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic [1:0]  state_dbg;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_count2;
`endif

  // Second instance: wrap-around reset PC, always acking.
  logic        w_stall, w_redirect, w_ack;
  logic [31:0] w_redirect_pc, w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc_out, w_instr;
  logic [1:0]  w_state;

  int vectors;
  int miscompares;
  bit chk_en;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
`ifdef FETCH_PERF_EN
    .fetch_count     (fetch_count),
`endif
    .state_dbg       (state_dbg)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .stall           (w_stall),
    .redirect        (w_redirect),
    .redirect_pc     (w_redirect_pc),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_ack        (w_ack),
    .imem_rdata      (w_rdata),
    .PC_out          (w_pc_out),
    .instruction_out (w_instr),
    .valid_out       (w_valid),
`ifdef FETCH_PERF_EN
    .fetch_count     (fetch_count2),
`endif
    .state_dbg       (w_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Abstract view: is a request outstanding, is a word parked in the stall
  // buffer, is an old request being waited out after a redirect.
  logic [31:0] m_pc, m_drain_addr, m_buf_pc, m_pc_out, m_instr, m_count;
  bit          m_started, m_hold, m_drain, m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  function automatic bit m_req();
    return m_started && !m_hold;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  function automatic logic [1:0] m_state();
    return m_hold ? S_HOLD : (m_drain ? S_DRAIN : S_REQ);
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_drain_addr = 32'h0; m_buf_pc = 32'h0;
    m_pc_out = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    m_started = 0; m_hold = 0; m_drain = 0; m_valid = 0;
  endtask

  task automatic m_deliver(input logic [31:0] instr, input logic [31:0] next_pc);
    m_instr  = instr;
    m_pc_out = next_pc;
    m_valid  = 1;
    m_count  = m_count + 1;
  endtask

  task automatic m_bubble();
    m_instr = 32'h0;
    m_valid = 0;
  endtask

  task automatic m_step(input bit ack, input bit stl, input bit redir, input logic [31:0] rpc);
    bit got;
    got = ack && m_req();
    if (redir) begin
      m_bubble();
      if (m_hold) m_hold = 0;
      else if (m_drain) begin
        if (got) m_drain = 0;
      end else if (m_req() && !ack) begin
        m_drain = 1;
        m_drain_addr = m_pc;
      end
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (m_drain) begin
      if (got) m_drain = 0;
      if (!stl) m_bubble();
    end else if (m_hold) begin
      if (!stl) begin
        m_deliver(mem_word(m_pc), m_buf_pc);
        m_pc = m_pc + 4;
        m_hold = 0;
      end
    end else if (got) begin
      if (stl) begin
        m_hold = 1;
        m_buf_pc = m_pc + 4;
      end else begin
        m_deliver(mem_word(m_pc), m_pc + 4);
        m_pc = m_pc + 4;
      end
    end else if (!stl) begin
      m_bubble();
    end
    m_started = 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(m_req()));
      if (m_req()) chk("imem_addr", imem_addr, m_addr());
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("instruction_out", instruction_out, m_instr);
      chk("PC_out", PC_out, m_pc_out);
      chk("state", 32'(state_dbg), 32'(m_state()));
`ifdef FETCH_PERF_EN
      chk("fetch_count", fetch_count, m_count);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit a, input bit s, input bit r, input logic [31:0] rp);
    imem_ack    = a;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    imem_rdata  = a ? mem_word(m_addr()) : $urandom;
    @(posedge clk);
    m_step(a, s, r, rp);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ack = 0; imem_rdata = 0;
    w_stall = 0; w_redirect = 0; w_redirect_pc = 0; w_ack = 1; w_rdata = 32'hDEAD_BEEF;
    m_reset();
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back acks from reset; wrap instance checked alongside.
    cyc(1, 0, 0, 0);
    chk("lit_first_req", 32'(imem_req), 32'd1);
    chk("lit_first_addr", imem_addr, 32'h0);
    chk("lit_first_valid", 32'(valid_out), 32'd0);
    chk("lit_wrap_addr0", w_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("lit_instr0", instruction_out, 32'h100);
    chk("lit_pc0", PC_out, 32'h4);
    chk("lit_valid0", 32'(valid_out), 32'd1);
    chk("lit_wrap_addr1", w_addr, 32'h0);
    chk("lit_wrap_pc_out", w_pc_out, 32'h0);
    chk("lit_wrap_instr", w_instr, 32'hDEAD_BEEF);
    chk("lit_wrap_valid", 32'(w_valid), 32'd1);
    chk("lit_wrap_state", 32'(w_state), 32'(S_REQ));
    cyc(1, 0, 0, 0);
    chk("lit_instr1", instruction_out, 32'h101);
    chk("lit_pc1", PC_out, 32'h8);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Stall coincident with the ack of 0x10.
    cyc(1, 1, 0, 0);
    chk("lit_hold_state", 32'(state_dbg), 32'(S_HOLD));
    chk("lit_hold_instr", instruction_out, 32'h103);
    chk("lit_hold_pc", PC_out, 32'h10);
    chk("lit_hold_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 0, 0);
    chk("lit_hold2_valid", 32'(valid_out), 32'd1);
    cyc(0, 0, 0, 0);
    chk("lit_unhold_instr", instruction_out, 32'h104);
    chk("lit_unhold_pc", PC_out, 32'h14);

    // Three wait states before the ack.
    for (int i = 0; i < 4; i++) begin
      chk("lit_wait_addr", imem_addr, 32'h14);
      cyc((i == 3), 0, 0, 0);
      if (i < 3) chk("lit_wait_valid", 32'(valid_out), 32'd0);
    end
    chk("lit_waited_instr", instruction_out, 32'h105);
    chk("lit_waited_pc", PC_out, 32'h18);

    // Redirect while a request is pending.
    cyc(0, 0, 1, 32'h403);
    chk("lit_drain_state", 32'(state_dbg), 32'(S_DRAIN));
    chk("lit_drain_addr", imem_addr, 32'h18);
    chk("lit_drain_valid", 32'(valid_out), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("lit_after_drain_addr", imem_addr, 32'h400);
    chk("lit_after_drain_valid", 32'(valid_out), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("lit_target_instr", instruction_out, 32'h200);
    chk("lit_target_pc", PC_out, 32'h404);

    // Reset mid-request; a stray ack right after must be ignored.
    do_reset(1);
    cyc(1, 0, 0, 0);
    chk("lit_rst_valid", 32'(valid_out), 32'd0);
    chk("lit_rst_addr", imem_addr, 32'h0);
    chk("lit_rst_req", 32'(imem_req), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit a, s, r;
      logic [31:0] rp;
      if (i % 700 == 350) do_reset(1 + $urandom_range(0, 1));
      a  = ($urandom_range(0, 9) < 6);
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(a, s, r, rp);
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
